serial_tx: RTL

Byte-serialising transmitter: accepts an 8-bit parallel word with a Load strobe and shifts it out on a single line as a UART-style frame (start bit, 8 data bits LSB first, stop bit). It is the serial output stage behind the team's 8-bit Register blocks. It turns a latched parallel byte into a bit stream for an off-chip link or a matching serial receiver. A Busy/Done pair lets the upstream control logic pace loads.

---
 rtl/serial_tx.sv | 117 +++++++++++
 1 files changed

// File: rtl/serial_tx.sv
// UART-style byte serialiser: start bit, 8 data bits LSB first, stop bit.
// All outputs are registered; Busy/Done let upstream logic pace loads.
module serial_tx #(
  parameter int unsigned ClksPerBit = 16
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [7:0] i_data_in,
  input  logic       i_load,
  output logic       o_tx_out,
  output logic       o_busy,
  output logic       o_done
);

  localparam int unsigned CntW = (ClksPerBit > 2) ? $clog2(ClksPerBit) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(ClksPerBit - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e          r_state, w_state_nxt;
  logic [7:0]      r_shift, w_shift_nxt;
  logic [CntW-1:0] r_baud_cnt, w_baud_cnt_nxt;
  logic [2:0]      r_bit_idx, w_bit_idx_nxt;
  logic            r_tx, w_tx_nxt;
  logic            r_busy, w_busy_nxt;
  logic            r_done, w_done_nxt;
  logic            w_bit_end;

  assign w_bit_end = (r_baud_cnt == CntMax);

  always_comb begin
    w_state_nxt    = r_state;
    w_shift_nxt    = r_shift;
    w_baud_cnt_nxt = r_baud_cnt;
    w_bit_idx_nxt  = r_bit_idx;
    w_busy_nxt     = r_busy;
    w_done_nxt     = 1'b0;
    w_tx_nxt       = 1'b1;

    unique case (r_state)
      StIdle: begin
        if (i_load) begin
          w_state_nxt    = StStart;
          w_shift_nxt    = i_data_in;
          w_baud_cnt_nxt = '0;
          w_bit_idx_nxt  = '0;
          w_busy_nxt     = 1'b1;
        end
      end
      StStart: begin
        if (w_bit_end) begin
          w_baud_cnt_nxt = '0;
          w_state_nxt    = StData;
        end else begin
          w_baud_cnt_nxt = r_baud_cnt + CntW'(1);
        end
      end
      StData: begin
        if (w_bit_end) begin
          w_baud_cnt_nxt = '0;
          w_shift_nxt    = {1'b0, r_shift[7:1]};
          w_bit_idx_nxt  = r_bit_idx + 3'd1;
          if (r_bit_idx == 3'd7) begin
            w_state_nxt = StStop;
          end
        end else begin
          w_baud_cnt_nxt = r_baud_cnt + CntW'(1);
        end
      end
      StStop: begin
        if (w_bit_end) begin
          w_baud_cnt_nxt = '0;
          w_state_nxt    = StIdle;
          w_busy_nxt     = 1'b0;
          w_done_nxt     = 1'b1;
        end else begin
          w_baud_cnt_nxt = r_baud_cnt + CntW'(1);
        end
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase

    // Line level is derived from the next state so TxOut stays a plain register.
    unique case (w_state_nxt)
      StStart: w_tx_nxt = 1'b0;
      StData:  w_tx_nxt = w_shift_nxt[0];
      default: w_tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= StIdle;
      r_shift    <= '0;
      r_baud_cnt <= '0;
      r_bit_idx  <= '0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_shift    <= w_shift_nxt;
      r_baud_cnt <= w_baud_cnt_nxt;
      r_bit_idx  <= w_bit_idx_nxt;
      r_tx       <= w_tx_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
    end
  end

  assign o_tx_out = r_tx;
  assign o_busy   = r_busy;
  assign o_done   = r_done;

endmodule
